// File: rtl/datapath_ctrl_4bits.sv
// +----------------------------------------------------------------------------+
// | Module  : datapath_ctrl_4bits                                              |
// | Brief   : Instruction sequencer driving the 4-bit register-file/ALU path.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module datapath_ctrl_4bits #(
  parameter int unsigned EXEC_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  dados,
  output logic [2:0]  opcode,
  output logic [1:0]  reg_addr,
  output logic        write_enable,
  output logic        sel12,
  output logic        sel21,
  output logic        carry_in,
  output logic        done,
  output logic        busy,
  output logic [7:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDI  = 3'd1,
    S_RDA  = 3'd2,
    S_RDB  = 3'd3,
    S_LATB = 3'd4,
    S_WAIT = 3'd5,
    S_WB   = 3'd6
  } state_t;

  localparam logic [2:0] C_WAIT_LOAD = 3'(EXEC_WAIT);

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        retire;

  logic [3:0]  dados_q, dados_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [1:0]  reg_addr_q, reg_addr_d;
  logic        write_enable_q, write_enable_d;
  logic        sel12_q, sel12_d;
  logic        sel21_q, sel21_d;
  logic        carry_in_q, carry_in_d;
  logic        done_q, done_d;
  logic [7:0]  instr_count_q, instr_count_d;

  logic [1:0]  f_class;
  logic [2:0]  f_op;
  logic [1:0]  f_rd, f_rs1, f_rs2;
  logic        f_cin;
  logic [3:0]  f_imm;

  // Outputs are decoded from the upcoming state so they are valid for the whole state.
  assign f_class = instr_d[15:14];
  assign f_op    = instr_d[13:11];
  assign f_rd    = instr_d[10:9];
  assign f_rs1   = instr_d[8:7];
  assign f_rs2   = instr_d[6:5];
  assign f_cin   = instr_d[4];
  assign f_imm   = instr_d[3:0];

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          case (instr[15:14])
            2'b00:   state_d = S_LDI;
            2'b01:   state_d = S_RDA;
            default: retire  = 1'b1;
          endcase
        end
      end
      S_LDI: begin
        state_d = S_IDLE;
        retire  = 1'b1;
      end
      S_RDA:  state_d = S_RDB;
      S_RDB:  state_d = S_LATB;
      S_LATB: begin
        if (EXEC_WAIT == 0) begin
          state_d = S_WB;
        end else begin
          state_d    = S_WAIT;
          wait_cnt_d = C_WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 3'd1) state_d = S_WB;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      S_WB: begin
        state_d = S_IDLE;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dados_d        = dados_q;
    opcode_d       = opcode_q;
    reg_addr_d     = reg_addr_q;
    sel12_d        = sel12_q;
    sel21_d        = sel21_q;
    carry_in_d     = carry_in_q;
    write_enable_d = 1'b0;
    done_d         = retire;
    instr_count_d  = retire ? instr_count_q + 8'd1 : instr_count_q;
    case (state_d)
      S_LDI: begin
        reg_addr_d     = f_rd;
        dados_d        = f_imm;
        sel21_d        = 1'b0;
        write_enable_d = 1'b1;
      end
      S_RDA: begin
        reg_addr_d = f_rs1;
        sel12_d    = 1'b0;
      end
      S_RDB: begin
        reg_addr_d = f_rs2;
        sel12_d    = 1'b0;
      end
      S_LATB, S_WAIT: begin
        reg_addr_d = f_rs2;
        sel12_d    = 1'b1;
        opcode_d   = f_op;
        carry_in_d = f_cin;
      end
      S_WB: begin
        reg_addr_d     = f_rd;
        sel12_d        = 1'b1;
        sel21_d        = 1'b1;
        write_enable_d = 1'b1;
        opcode_d       = f_op;
        carry_in_d     = f_cin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      wait_cnt_q     <= '0;
      dados_q        <= '0;
      opcode_q       <= '0;
      reg_addr_q     <= '0;
      write_enable_q <= 1'b0;
      sel12_q        <= 1'b0;
      sel21_q        <= 1'b0;
      carry_in_q     <= 1'b0;
      done_q         <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      wait_cnt_q     <= wait_cnt_d;
      dados_q        <= dados_d;
      opcode_q       <= opcode_d;
      reg_addr_q     <= reg_addr_d;
      write_enable_q <= write_enable_d;
      sel12_q        <= sel12_d;
      sel21_q        <= sel21_d;
      carry_in_q     <= carry_in_d;
      done_q         <= done_d;
      instr_count_q  <= instr_count_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign busy         = ~instr_ready;
  assign dados        = dados_q;
  assign opcode       = opcode_q;
  assign reg_addr     = reg_addr_q;
  assign write_enable = write_enable_q;
  assign sel12        = sel12_q;
  assign sel21        = sel21_q;
  assign carry_in     = carry_in_q;
  assign done         = done_q;
  assign instr_count  = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_ctrl_4bits.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_datapath_ctrl_4bits                                           |
// | Brief   : Self-checking bench with an attached 4-bit datapath model.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_datapath_ctrl_4bits;

  localparam int EW  = 0;
  localparam int EW2 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0, instr2 = '0;
  logic        instr_valid = 1'b0, instr_valid2 = 1'b0;

  logic        instr_ready, write_enable, sel12, sel21, carry_in, done, busy;
  logic [3:0]  dados;
  logic [2:0]  opcode;
  logic [1:0]  reg_addr;
  logic [7:0]  instr_count;

  logic        instr_ready2, write_enable2, sel12_2, sel21_2, carry_in2, done2, busy2;
  logic [3:0]  dados2;
  logic [2:0]  opcode2;
  logic [1:0]  reg_addr2;
  logic [7:0]  instr_count2;

  int checks = 0;
  int errors = 0;

  datapath_ctrl_4bits #(.EXEC_WAIT(EW)) u_dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dados(dados), .opcode(opcode), .reg_addr(reg_addr),
    .write_enable(write_enable), .sel12(sel12), .sel21(sel21), .carry_in(carry_in),
    .done(done), .busy(busy), .instr_count(instr_count)
  );

  datapath_ctrl_4bits #(.EXEC_WAIT(EW2)) u_dut_w3 (
    .clk(clk), .rst(rst), .instr(instr2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .dados(dados2), .opcode(opcode2), .reg_addr(reg_addr2),
    .write_enable(write_enable2), .sel12(sel12_2), .sel21(sel21_2), .carry_in(carry_in2),
    .done(done2), .busy(busy2), .instr_count(instr_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [1:0] cls, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] rs1,
                                      input logic [1:0] rs2, input logic cin,
                                      input logic [3:0] imm);
    return {cls, op, rd, rs1, rs2, cin, imm};
  endfunction

  function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic c);
    case (op)
      3'd0:    return a + b + {3'b000, c};
      3'd1:    return a - b - {3'b000, c};
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a;
      default: return b;
    endcase
  endfunction

  // Datapath attached to the sequencer: registered RF read, operand regs A/B, ALU, write mux.
  logic [3:0] rf_m [4] = '{default: 4'd0};
  logic [3:0] rdq = '0, opa = '0, opb = '0;
  int         cyc = 0, wr_cnt = 0, wr_cyc = 0;
  logic [1:0] wr_addr = '0;
  logic       wr_sel21 = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdq <= rf_m[reg_addr];
    if (sel12) opb <= rdq;
    else       opa <= rdq;
    if (write_enable) begin
      rf_m[reg_addr] <= sel21 ? alu(opcode, opa, opb, carry_in) : dados;
      wr_cnt   <= wr_cnt + 1;
      wr_cyc   <= cyc;
      wr_addr  <= reg_addr;
      wr_sel21 <= sel21;
    end
  end

  // Architectural reference: register contents and retire count per instruction.
  logic [3:0] rf_ref [4] = '{default: 4'd0};
  logic [7:0] cnt_ref = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf();
    for (int r = 0; r < 4; r++) chk($sformatf("rf[%0d]", r), 32'(rf_m[r]), 32'(rf_ref[r]));
  endtask

  task automatic run(input logic [15:0] w);
    int   acc, wc, exp_lat;
    bit   got;
    logic [1:0] cls;
    cls = w[15:14];
    chk("ready_before_accept", 32'(instr_ready), 32'd1);
    instr = w;
    instr_valid = 1'b1;
    wc = wr_cnt;
    @(negedge clk);
    acc = cyc;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      instr_valid = 1'($urandom_range(0, 1));
      instr = 16'($urandom);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    exp_lat = (cls == 2'b00) ? 1 : (cls == 2'b01) ? 4 + EW : 0;
    chk("retire_latency", 32'(cyc - acc), 32'(exp_lat));
    chk("write_count", 32'(wr_cnt - wc), (cls[1] == 1'b0) ? 32'd1 : 32'd0);
    if (cls[1] == 1'b0) begin
      chk("write_addr", 32'(wr_addr), 32'(w[10:9]));
      chk("write_sel21", 32'(wr_sel21), 32'(cls == 2'b01));
      chk("write_edge", 32'(wr_cyc + 1), 32'(cyc));
      rf_ref[w[10:9]] = (cls == 2'b00) ? w[3:0]
                      : alu(w[13:11], rf_ref[w[8:7]], rf_ref[w[6:5]], w[4]);
    end
    cnt_ref = cnt_ref + 8'd1;
    chk("instr_count", 32'(instr_count), 32'(cnt_ref));
    chk_rf();
  endtask

  // Launch an ALU instruction and pull reset n cycles after the accept edge.
  task automatic abort_at(input int n);
    int wc;
    instr = enc(2'b01, 3'($urandom), 2'd3, 2'd0, 2'd1, 1'b0, 4'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
    if (n == 4) chk("pre_abort_we", 32'(write_enable), 32'd1);
    wc = wr_cnt;
    rst = 1'b1;
    #1;
    chk("abort_we_async", 32'(write_enable), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(instr_count), 32'd0);
    cnt_ref = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt - wc), 32'd0);
    chk_rf();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_sel, bad_rdy, wb_at;
    logic [15:0] w;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", 32'({done, write_enable, dados, opcode, reg_addr, sel12, sel21, carry_in}), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    rst = 1'b0;

    // Back-to-back LDI with valid held high.
    instr = enc(2'b00, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd7);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("ldi0_we_addr_imm", 32'({write_enable, reg_addr, dados}), 32'({1'b1, 2'd0, 4'd7}));
    chk("ldi0_ready", 32'(instr_ready), 32'd0);
    instr = enc(2'b00, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd1);
    @(negedge clk);
    chk("ldi0_done", 32'({done, instr_ready, instr_count}), 32'({1'b1, 1'b1, 8'd1}));
    @(negedge clk);
    chk("ldi1_we_addr_imm", 32'({write_enable, reg_addr, dados, done}), 32'({1'b1, 2'd1, 4'd1, 1'b0}));
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ldi1_done", 32'({done, instr_count}), 32'({1'b1, 8'd2}));
    rf_ref[0] = 4'd7;
    rf_ref[1] = 4'd1;
    cnt_ref = 8'd2;
    chk_rf();

    // ALU add r2 = r0 + r1, then subtract with and without borrow.
    run(enc(2'b01, 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0));
    chk("add_result", 32'(rf_m[2]), 32'd8);
    run(enc(2'b00, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5));
    run(enc(2'b00, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 4'd3));
    run(enc(2'b01, 3'd1, 2'd3, 2'd0, 2'd1, 1'b0, 4'd0));
    chk("sub_result", 32'(rf_m[3]), 32'd2);
    run(enc(2'b01, 3'd1, 2'd3, 2'd0, 2'd1, 1'b1, 4'd0));
    chk("sub_borrow_result", 32'(rf_m[3]), 32'd1);

    // EXEC_WAIT=3 instance: LATB plus three WAIT cycles before write-back.
    instr2 = enc(2'b01, 3'd0, 2'd1, 2'd2, 2'd3, 1'b0, 4'd0);
    instr_valid2 = 1'b1;
    @(negedge clk);
    instr_valid2 = 1'b0;
    n_sel = 0;
    bad_rdy = 0;
    wb_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (instr_ready2) bad_rdy++;
      if (write_enable2) begin
        wb_at = i;
        break;
      end
      if (sel12_2) n_sel++;
      @(negedge clk);
    end
    chk("w3_write_edge", 32'(wb_at), 32'(4 + EW2));
    chk("w3_sel12_cycles", 32'(n_sel), 32'(1 + EW2));
    chk("w3_ready_low", 32'(bad_rdy), 32'd0);
    @(negedge clk);
    chk("w3_done", 32'({done2, instr_ready2, instr_count2}), 32'({1'b1, 1'b1, 8'd1}));

    // Reset during RDB and during WB; the following LDI must behave normally.
    abort_at(2);
    run(enc(2'b00, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 4'd9));
    abort_at(4);
    run(enc(2'b00, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 4'd4));

    // Fresh count: a NOP followed by 256 random instructions wraps the counter to 1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_ref = 8'd0;
    @(negedge clk);
    run(16'h8000);
    for (int k = 0; k < 256; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 16'($urandom);
      run(w);
    end
    chk("count_wrap", 32'(instr_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
